acq_controller: RTL and testbench

Acquisition sequencer sitting between the front-panel/host control logic and the `sampler`. Each sweep: arms the sampler, supplies an auto-mode forced trigger on timeout, and streams the finished 2^SAMPLE_DEPTH-sample record out of sample memory oldest-first, starting at the trigger-relative start address. Applies a holdoff, then re-arms or stops according to the trigger mode.

---
 rtl/oscilo_pkg.sv | 21 ++
 rtl/rd_skid.sv | 71 +++++++
 rtl/acq_controller.sv | 147 ++++++++++++++
 tb/tb_acq_controller.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/oscilo_pkg.sv
// Shared types for the acquisition path: trigger modes and sequencer states.
package oscilo_pkg;

  localparam int DEF_SAMPLE_DEPTH = 8;

  typedef enum logic [1:0] {
    MODE_STOP   = 2'd0,
    MODE_AUTO   = 2'd1,
    MODE_NORMAL = 2'd2,
    MODE_SINGLE = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT,
    ST_READ,
    ST_HOLD
  } state_e;

endpackage

// File: rtl/rd_skid.sv
// Two-entry landing buffer for a 1-cycle-latency memory read port.
// A read is issued only when the output register plus skid register are
// guaranteed to have room for its data, so no sample is ever dropped.
module rd_skid #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          req_last,
  output logic          rd_en,
  input  logic [DW-1:0] rd_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready
);

  logic          inflight, inflight_last;
  logic          last_q;
  logic          skid_vld, skid_last;
  logic [DW-1:0] skid_data;
  logic          pop;
  logic [1:0]    occ;

  assign pop = out_valid & out_ready;
  // Entries held after this edge, counting the read already in flight.
  assign occ = {1'b0, out_valid} + {1'b0, skid_vld} + {1'b0, inflight} - {1'b0, pop};
  assign rd_en    = req & (occ <= 2'd1);
  assign out_last = out_valid & last_q;

  // Ordered two-deep queue: output register is the head, skid the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      last_q        <= 1'b0;
      skid_vld      <= 1'b0;
      skid_data     <= '0;
      skid_last     <= 1'b0;
    end else begin
      inflight      <= rd_en;
      inflight_last <= rd_en & req_last;
      if (!out_valid || pop) begin
        if (skid_vld) begin
          out_valid <= 1'b1;
          out_data  <= skid_data;
          last_q    <= skid_last;
          skid_vld  <= inflight;
          if (inflight) begin
            skid_data <= rd_data;
            skid_last <= inflight_last;
          end
        end else if (inflight) begin
          out_valid <= 1'b1;
          out_data  <= rd_data;
          last_q    <= inflight_last;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (inflight) begin
        skid_vld  <= 1'b1;
        skid_data <= rd_data;
        skid_last <= inflight_last;
      end
    end
  end

endmodule

// File: rtl/acq_controller.sv
// Acquisition sequencer: arms the sampler, forces a trigger on auto-mode
// timeout, streams the finished record oldest-first, then holds off and
// re-arms or stops depending on the trigger mode.
module acq_controller
  import oscilo_pkg::*;
#(
  parameter int          SAMPLE_DEPTH = DEF_SAMPLE_DEPTH,
  parameter int unsigned AUTO_TIMEOUT = 5_000_000,
  parameter int unsigned HOLDOFF      = 1000
) (
  input  logic                    clk_50mhz,
  input  logic                    reset,
  input  logic [1:0]              mode,
  input  logic                    arm,
  output logic                    smp_activate,
  input  logic                    smp_done,
  output logic                    force_trig,
  input  logic [SAMPLE_DEPTH-1:0] rec_start,
  output logic                    mem_rd_en,
  output logic [SAMPLE_DEPTH-1:0] mem_rd_addr,
  input  logic [7:0]              mem_rd_data,
  output logic                    out_valid,
  output logic [7:0]              out_data,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    auto_trig
);

  localparam logic [SAMPLE_DEPTH:0] N_RD     = {1'b1, {SAMPLE_DEPTH{1'b0}}};
  localparam logic [31:0]           TMO_LAST = 32'(AUTO_TIMEOUT - 1);
  localparam logic [15:0]           HLD_LAST = 16'(HOLDOFF - 1);

  state_e                  state, nxt;
  mode_e                   mode_in, mode_q;
  logic [31:0]             tmo_cnt;
  logic [15:0]             hold_cnt;
  logic [SAMPLE_DEPTH:0]   rd_cnt;
  logic [SAMPLE_DEPTH-1:0] rd_ptr;
  logic                    forced;
  logic                    done_seen, fire_tmo, last_acc;
  logic                    rd_req, rd_req_last;

  assign mode_in     = mode_e'(mode);
  assign mem_rd_addr = rd_ptr;
  // Sampler clears done during its first setup cycles; ignore it until then.
  assign done_seen = (state == ST_WAIT) && (tmo_cnt >= 32'd2) && smp_done;
  assign fire_tmo  = (state == ST_WAIT) && (mode_q == MODE_AUTO) && (tmo_cnt == TMO_LAST)
                     && !forced && !done_seen;
  assign last_acc  = out_valid & out_ready & out_last;

  // State register
  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= nxt;
  end

  // Next-state logic; mode is only sampled in IDLE and at the end of HOLD
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: begin
        if (mode_in == MODE_AUTO || mode_in == MODE_NORMAL) nxt = ST_ARM;
        else if (mode_in == MODE_SINGLE && arm)             nxt = ST_ARM;
      end
      ST_ARM:  nxt = ST_WAIT;
      ST_WAIT: if (done_seen) nxt = ST_READ;
      ST_READ: if (last_acc)  nxt = ST_HOLD;
      ST_HOLD: begin
        if (hold_cnt == HLD_LAST)
          nxt = (mode_q == MODE_SINGLE || mode_in == MODE_STOP) ? ST_IDLE : ST_ARM;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // Output decode from current state
  always_comb begin
    busy        = (state != ST_IDLE);
    rd_req      = (state == ST_READ) && (rd_cnt != N_RD);
    rd_req_last = (rd_cnt == N_RD - 1'b1);
  end

  // Registered one-cycle pulses to the sampler and trigger logic
  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      smp_activate <= 1'b0;
      force_trig   <= 1'b0;
    end else begin
      smp_activate <= (nxt == ST_ARM);
      force_trig   <= fire_tmo;
    end
  end

  // Sweep counters, read pointer and trigger-source flag
  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      mode_q    <= MODE_STOP;
      tmo_cnt   <= '0;
      hold_cnt  <= '0;
      rd_cnt    <= '0;
      rd_ptr    <= '0;
      forced    <= 1'b0;
      auto_trig <= 1'b0;
    end else begin
      case (state)
        ST_ARM: begin
          mode_q  <= mode_in;
          tmo_cnt <= '0;
          forced  <= 1'b0;
        end
        ST_WAIT: begin
          if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + 1'b1;
          if (fire_tmo)      forced  <= 1'b1;
          if (done_seen) begin
            rd_ptr    <= rec_start;
            rd_cnt    <= '0;
            auto_trig <= forced;
          end
        end
        ST_READ: begin
          hold_cnt <= '0;
          if (mem_rd_en) begin
            rd_ptr <= rd_ptr + 1'b1;
            rd_cnt <= rd_cnt + 1'b1;
          end
        end
        ST_HOLD: hold_cnt <= hold_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  rd_skid #(.DW(8)) u_skid (
    .clk       (clk_50mhz),
    .rst_n     (reset),
    .req       (rd_req),
    .req_last  (rd_req_last),
    .rd_en     (mem_rd_en),
    .rd_data   (mem_rd_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

endmodule

// File: tb/tb_acq_controller.sv
// Directed bench for acq_controller with a small sampler and memory model.
module tb_acq_controller;

  localparam int HOLD = 20;
  localparam int TMO  = 100;

  logic       clk_50mhz = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic       arm;
  logic       smp_activate;
  logic       smp_done = 1'b0;
  logic       force_trig;
  logic [7:0] rec_start;
  logic       mem_rd_en;
  logic [7:0] mem_rd_addr;
  logic [7:0] mem_rd_data = 8'h00;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;
  logic       busy;
  logic       auto_trig;

  int  n_cmp = 0;
  int  n_err = 0;
  bit  done_en = 1'b1;
  int  scnt = 0;
  logic [7:0] mem [256];

  always #10 clk_50mhz = ~clk_50mhz;

  acq_controller #(.SAMPLE_DEPTH(8), .AUTO_TIMEOUT(TMO), .HOLDOFF(HOLD)) dut (
    .clk_50mhz(clk_50mhz), .reset(reset), .mode(mode), .arm(arm),
    .smp_activate(smp_activate), .smp_done(smp_done), .force_trig(force_trig),
    .rec_start(rec_start), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_ready(out_ready), .busy(busy), .auto_trig(auto_trig)
  );

  // Sample memory, one cycle read latency
  always @(posedge clk_50mhz)
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  // Sampler: done drops on activate, rises a few cycles later when enabled
  always @(posedge clk_50mhz)
    if (smp_activate) begin
      smp_done <= 1'b0;
      scnt     <= 0;
    end else begin
      scnt     <= scnt + 1;
      smp_done <= done_en && (scnt >= 3);
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {9'd0, smp_activate, force_trig, mem_rd_en, mem_rd_addr, out_valid,
            out_data, out_last, busy, auto_trig};
  endfunction

  task automatic wait_act(input string tag, input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk_50mhz);
      n++;
    end while (!smp_activate && n < limit);
    chk(tag, 32'(smp_activate), 32'd1);
  endtask

  // Window with no re-arm, ending idle
  task automatic idle_check(input string tag);
    int acts = 0;
    for (int i = 0; i < 2 * HOLD + 10; i++) begin
      @(negedge clk_50mhz);
      if (smp_activate) acts++;
    end
    chk({tag, "_noact"}, 32'(acts), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Accept one full record and check order, last flag, stall stability and rate
  task automatic collect(input logic [7:0] start, input bit rnd, input bit exp_auto, input bit drop);
    int idx = 0, cyc = 0, first = -1;
    bit stalled = 1'b0;
    logic [7:0] held = '0, e;
    logic held_last = 1'b0;
    while (idx < 256 && cyc < 3000) begin
      @(negedge clk_50mhz);
      cyc++;
      if (stalled) chk("stall_hold", {22'd0, out_valid, out_last, out_data}, {22'd0, 1'b1, held_last, held});
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        if (first < 0) begin
          first = cyc;
          chk("auto_trig", 32'(auto_trig), 32'(exp_auto));
        end
        e = start + 8'(idx);
        chk("data", 32'(out_data), 32'(e));
        chk("last", 32'(out_last), 32'(idx == 255));
        idx++;
        if (drop && idx == 10) mode = 2'd0;
      end
      stalled   = out_valid && !out_ready;
      held      = out_data;
      held_last = out_last;
    end
    chk("samples", 32'(idx), 32'd256);
    if (!rnd) chk("rate", 32'(cyc - first), 32'd255);
    out_ready = 1'b1;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    reset = 1'b0; mode = 2'd0; arm = 1'b0; out_ready = 1'b1; rec_start = 8'hF0;
    repeat (3) @(negedge clk_50mhz);
    chk("reset_outs", outs(), 32'd0);
    reset = 1'b1;

    // Normal mode: stream from 0xF0, re-arm after holdoff, then stop
    mode = 2'd2;
    wait_act("norm_act", 5, n);
    @(negedge clk_50mhz);
    chk("act_pulse", 32'(smp_activate), 32'd0);
    collect(8'hF0, 1'b0, 1'b0, 1'b0);
    wait_act("norm_rearm", 100, n);
    chk("holdoff", 32'(n), 32'(HOLD + 1));
    mode = 2'd0;
    collect(8'hF0, 1'b0, 1'b0, 1'b0);
    idle_check("norm_stop");

    // Auto mode: forced trigger on timeout, once per sweep
    done_en = 1'b0; rec_start = 8'h10; mode = 2'd1;
    wait_act("auto_act", 5, n);
    n = 0;
    do begin
      @(negedge clk_50mhz);
      n++;
    end while (!force_trig && n < 300);
    chk("tmo_at", 32'(n), 32'(TMO + 1));
    @(negedge clk_50mhz);
    chk("tmo_pulse", 32'(force_trig), 32'd0);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_50mhz);
      if (force_trig) n++;
    end
    chk("tmo_once", 32'(n), 32'd0);
    chk("wait_busy", 32'(busy), 32'd1);
    done_en = 1'b1;
    collect(8'h10, 1'b0, 1'b1, 1'b0);
    rec_start = 8'h80;
    wait_act("auto_rearm", 100, n);
    chk("auto_holdoff", 32'(n), 32'(HOLD + 1));
    // Mode dropped to stop mid-readout: record still completes
    collect(8'h80, 1'b0, 1'b0, 1'b1);
    idle_check("auto_stop");

    // Single mode: nothing without arm, one sweep with it
    rec_start = 8'h33; mode = 2'd3;
    idle_check("single_noarm");
    arm = 1'b1;
    @(negedge clk_50mhz);
    arm = 1'b0;
    chk("single_act", 32'(smp_activate), 32'd1);
    collect(8'h33, 1'b1, 1'b0, 1'b0);
    idle_check("single_end");

    // Reset in WAIT
    done_en = 1'b0; mode = 2'd2;
    wait_act("rw_act", 5, n);
    repeat (5) @(negedge clk_50mhz);
    reset = 1'b0;
    #1;
    chk("rst_wait_outs", outs(), 32'd0);
    @(negedge clk_50mhz);
    reset = 1'b1;
    wait_act("rst_rearm", 3, n);

    // Reset in READ
    done_en = 1'b1;
    n = 0;
    do begin
      @(negedge clk_50mhz);
      n++;
    end while (!out_valid && n < 50);
    chk("rr_valid", 32'(out_valid), 32'd1);
    reset = 1'b0; mode = 2'd0;
    #1;
    chk("rst_read_outs", outs(), 32'd0);
    @(negedge clk_50mhz);
    reset = 1'b1;
    idle_check("rst_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
